// File: rtl/modexp_engine.sv
// ============================================================================
// modexp_engine : r = m^e mod n, right-to-left square-and-multiply built on
// two bit-serial interleaved modular multipliers. Option: MODEXP_EARLY_EXIT_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module modexp_engine #(
    parameter int BITS = 64
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [BITS-1:0] m,
    input  logic [BITS-1:0] e,
    input  logic [BITS-1:0] n,
    output logic [BITS-1:0] r,
    output logic            done,
    output logic            busy
);

    localparam int              c_CW   = $clog2(BITS + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REDUCE = 3'd1,
        S_MUL    = 3'd2,
        S_UPDATE = 3'd3,
        S_FIN    = 3'd4
    } state_t;

    state_t            r_state;
    logic [BITS-1:0]   r_n;
    logic [BITS-1:0]   r_e;
    logic [BITS-1:0]   r_base;
    logic [BITS-1:0]   r_acc;
    logic [BITS-1:0]   r_p1;
    logic [BITS-1:0]   r_p2;
    logic [BITS-1:0]   r_sa1;
    logic [BITS-1:0]   r_sa2;
    logic [c_CW-1:0]   r_bitcnt;
    logic [c_CW-1:0]   r_itcnt;

    logic [BITS-1:0]   w_one_n;
    logic [BITS-1:0]   w_one_in;
    logic [BITS-1:0]   w_b1;
    logic [BITS-1:0]   w_p1_nx;
    logic [BITS-1:0]   w_p2_nx;
    logic [BITS-1:0]   w_acc_upd;
    logic [BITS-1:0]   w_e_shr;
    logic              w_exit_update;
    logic              w_exit_reduce;

    // One interleaved step. P<N always holds, so P is kept in BITS bits while
    // the doubled / added intermediate needs BITS+1.
    function automatic logic [BITS-1:0] f_step(
        input logic [BITS-1:0] p,
        input logic            a_bit,
        input logic [BITS-1:0] b,
        input logic [BITS-1:0] nn
    );
        logic [BITS:0] t;
        logic [BITS:0] nw;
        nw = {1'b0, nn};
        t  = {p, 1'b0};
        if (t >= nw) t = t - nw;
        if (a_bit) begin
            t = t + {1'b0, b};
            if (t >= nw) t = t - nw;
        end
        return t[BITS-1:0];
    endfunction

    assign w_one_n   = (r_n == BITS'(1)) ? '0 : BITS'(1);
    assign w_one_in  = (n == BITS'(1)) ? '0 : BITS'(1);
    assign w_b1      = (r_state == S_REDUCE) ? w_one_n : r_base;
    assign w_p1_nx   = f_step(r_p1, r_sa1[BITS-1], w_b1, r_n);
    assign w_p2_nx   = f_step(r_p2, r_sa2[BITS-1], r_base, r_n);
    assign w_acc_upd = r_e[0] ? r_p1 : r_acc;
    assign w_e_shr   = r_e >> 1;

`ifdef MODEXP_EARLY_EXIT_EN
    assign w_exit_update = (r_itcnt == c_LAST) || (w_e_shr == '0);
    assign w_exit_reduce = (r_e == '0);
`else
    assign w_exit_update = (r_itcnt == c_LAST);
    assign w_exit_reduce = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state  <= S_IDLE;
            r_n      <= '0;
            r_e      <= '0;
            r_base   <= '0;
            r_acc    <= '0;
            r_p1     <= '0;
            r_p2     <= '0;
            r_sa1    <= '0;
            r_sa2    <= '0;
            r_bitcnt <= '0;
            r_itcnt  <= '0;
            r        <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_n      <= n;
                        r_e      <= e;
                        r_sa1    <= m;
                        r_p1     <= '0;
                        r_p2     <= '0;
                        r_bitcnt <= '0;
                        r_itcnt  <= '0;
                        done     <= 1'b0;
                        busy     <= 1'b1;
                        if (n == '0) begin
                            r_acc   <= '0;
                            r_state <= S_FIN;
                        end else begin
                            r_acc   <= w_one_in;
                            r_state <= S_REDUCE;
                        end
                    end
                end
                S_REDUCE: begin
                    r_p1     <= w_p1_nx;
                    r_sa1    <= r_sa1 << 1;
                    r_bitcnt <= r_bitcnt + 1'b1;
                    if (r_bitcnt == c_LAST) begin
                        // base = M mod N; preload both multiplier scan registers
                        r_base   <= w_p1_nx;
                        r_p1     <= '0;
                        r_bitcnt <= '0;
                        r_sa1    <= r_acc;
                        r_sa2    <= w_p1_nx;
                        r_state  <= w_exit_reduce ? S_FIN : S_MUL;
                    end
                end
                S_MUL: begin
                    r_p1     <= w_p1_nx;
                    r_p2     <= w_p2_nx;
                    r_sa1    <= r_sa1 << 1;
                    r_sa2    <= r_sa2 << 1;
                    r_bitcnt <= r_bitcnt + 1'b1;
                    if (r_bitcnt == c_LAST) begin
                        r_bitcnt <= '0;
                        r_state  <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    r_acc   <= w_acc_upd;
                    r_base  <= r_p2;
                    r_sa1   <= w_acc_upd;
                    r_sa2   <= r_p2;
                    r_p1    <= '0;
                    r_p2    <= '0;
                    r_e     <= w_e_shr;
                    r_itcnt <= r_itcnt + 1'b1;
                    r_state <= w_exit_update ? S_FIN : S_MUL;
                end
                S_FIN: begin
                    r       <= r_acc;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_modexp_engine.sv
// ============================================================================
// tb_modexp_engine : directed scoreboard bench for modexp_engine
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_modexp_engine;

    localparam int BITS = 64;

    logic            CLK = 1'b0;
    logic            RESET;
    logic            START;
    logic [BITS-1:0] m;
    logic [BITS-1:0] e;
    logic [BITS-1:0] n;
    logic [BITS-1:0] r;
    logic            done;
    logic            busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [BITS-1:0] exp_q[$];
    logic [BITS-1:0] last_exp;

    modexp_engine #(.BITS(BITS)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .START (START),
        .m     (m),
        .e     (e),
        .n     (n),
        .r     (r),
        .done  (done),
        .busy  (busy)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Reference: wide integer arithmetic with the % operator
    function automatic logic [BITS-1:0] model(input logic [BITS-1:0] mm,
                                              input logic [BITS-1:0] ee,
                                              input logic [BITS-1:0] nn);
        logic [2*BITS-1:0] b;
        logic [2*BITS-1:0] acc;
        logic [2*BITS-1:0] nw;
        if (nn == '0) return '0;
        nw  = {{BITS{1'b0}}, nn};
        b   = {{BITS{1'b0}}, mm} % nw;
        acc = 1 % nw;
        for (int i = 0; i < BITS; i++) begin
            if (ee[i]) acc = (acc * b) % nw;
            b = (b * b) % nw;
        end
        return acc[BITS-1:0];
    endfunction

    function automatic int lat(input logic [BITS-1:0] ee, input logic [BITS-1:0] nn);
        int l;
        if (nn == '0) return 1;
`ifdef MODEXP_EARLY_EXIT_EN
        l = 0;
        for (int i = 0; i < BITS; i++) if (ee[i]) l = i + 1;
`else
        l = BITS;
`endif
        return BITS + l * (BITS + 1) + 1;
    endfunction

    task automatic check(input string tag, input logic [BITS-1:0] obs, input logic [BITS-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_op(input logic [BITS-1:0] mm, input logic [BITS-1:0] ee,
                            input logic [BITS-1:0] nn, output int k);
        m = mm; e = ee; n = nn; START = 1'b1;
        tick();
        START = 1'b0;
        k = cyc;
        exp_q.push_back(model(mm, ee, nn));
        check("busy_at_start", {63'd0, busy}, 64'd1);
        check("done_drop_at_start", {63'd0, done}, 64'd0);
    endtask

    task automatic finish_op(input string tag, input int k, input int explat);
        int guard;
        logic [BITS-1:0] ev;
        guard = 0;
        while (!done && guard < explat + 20) begin
            tick();
            guard++;
        end
        check({tag, "_done"}, {63'd0, done}, 64'd1);
        if (done) begin
            check({tag, "_latency"}, 64'(cyc - k), 64'(explat));
            check({tag, "_busy_low"}, {63'd0, busy}, 64'd0);
            if (exp_q.size() > 0) begin
                ev = exp_q.pop_front();
                last_exp = ev;
                check({tag, "_result"}, r, ev);
            end
        end
    endtask

    task automatic run(input string tag, input logic [BITS-1:0] mm,
                       input logic [BITS-1:0] ee, input logic [BITS-1:0] nn);
        int k;
        start_op(mm, ee, nn, k);
        finish_op(tag, k, lat(ee, nn));
    endtask

    initial begin
        int k;
        RESET = 1'b1; START = 1'b0; m = '0; e = '0; n = '0;
        last_exp = '0;
        repeat (3) tick();
        RESET = 1'b0;
        check("reset_r", r, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);

        run("m4e13", 64'd4, 64'd13, 64'd497);
        check("m4e13_const", r, 64'd445);
        run("rsa_enc", 64'd65, 64'd17, 64'd3233);
        check("rsa_enc_const", r, 64'd2790);
        run("rsa_dec", 64'd2790, 64'd2753, 64'd3233);
        check("rsa_dec_const", r, 64'd65);
        run("m_ge_n", 64'd1000, 64'd1, 64'd7);
        run("e_zero", 64'd2, 64'd0, 64'd7);
        run("n_one", 64'd5, 64'd3, 64'd1);
        run("n_zero", 64'd9, 64'd9, 64'd0);
        run("wide", 64'hFEDC_BA98_7654_3210, 64'hF00F_0000_1234_8001, 64'hFFFF_FFFF_FFFF_FFC5);

        // START pulses while busy must be ignored
        start_op(64'd4, 64'd13, 64'd497, k);
        repeat (10) tick();
        for (int i = 0; i < 3; i++) begin
            m = 64'd1 + 64'(i); e = 64'd1; n = 64'd5; START = 1'b1;
            tick();
            START = 1'b0;
            repeat (37) tick();
        end
        check("busy_ignore_still_busy", {63'd0, busy}, 64'd1);
        finish_op("busy_ignore", k, lat(64'd13, 64'd497));

        // RESET mid-operation abandons the run
        start_op(64'd65, 64'd17, 64'd3233, k);
        void'(exp_q.pop_back());
        while (cyc < k + 99) tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("midrst_done", {63'd0, done}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_r", r, 64'd0);

        // RESET and START together: RESET wins
        RESET = 1'b1; START = 1'b1;
        tick();
        RESET = 1'b0; START = 1'b0;
        check("rst_start_busy", {63'd0, busy}, 64'd0);
        tick();
        check("rst_start_idle", {63'd0, busy}, 64'd0);

        run("after_rst", 64'd65, 64'd17, 64'd3233);

        // Result and done hold while inputs wander
        for (int i = 0; i < 50; i++) begin
            m = 64'($urandom); e = 64'($urandom); n = 64'($urandom);
            tick();
            check("hold_r", r, last_exp);
            check("hold_done", {63'd0, done}, 64'd1);
        end
        start_op(64'd2790, 64'd2753, 64'd3233, k);
        check("restart_r_held", r, 64'd2790);
        finish_op("restart", k, lat(64'd2753, 64'd3233));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/modexp_engine.md
# modexp_engine

Hardware side of the RSA operand/result interface. Computes r = m^e mod n using right-to-left binary square-and-multiply built on two parallel bit-serial interleaved modular multipliers. Consumes the message, exponent and modulus registers loaded by the operand memory. Returns a held result plus a level done flag that the memory captures and double-synchronises.

## Interface
- BITS, 64, operand/result width in bits

- CLK  in  1  clock, all logic on posedge
- RESET  in  1  synchronous, active-high; returns the block to IDLE
- START  in  1  begin operation; sampled only in IDLE
- m  in  BITS  message
- e  in  BITS  exponent
- n  in  BITS  modulus
- r  out  BITS  result; valid while done=1
- done  out  1  level; high from completion until next accepted START or RESET
- busy  out  1  high in every state except IDLE

## Operation
- Internal regs: M, E (shift register), N, base, acc, P (BITS+1 bits), bit counter, iteration counter.
- States are IDLE, REDUCE, MUL, UPDATE, FIN.
- IDLE: on START, latch m/e/n into M/E/N and deassert done. Later changes on m/e/n are ignored. START outside IDLE is ignored.
  - If n==0: go to FIN with r=0.
  - Otherwise go to REDUCE.
- one_n = (N==1) ? 0 : 1. acc initialises to one_n.
- Modmul step (a,b), BITS cycles, a scanned MSB first:
  - P ← 2P; if P≥N then P ← P−N.
  - If a[i]: P ← P+b; if P≥N then P ← P−N.
  - Both conditional subtracts happen in one cycle.
  - Invariant: P<N, so a (BITS+1)-bit datapath suffices.
- REDUCE: base = modmul(M, one_n), i.e. M mod N, over BITS cycles. Then go to MUL.
- MUL: run two multipliers concurrently for BITS cycles.
  - Multiplier 1: acc·base.
  - Multiplier 2: base·base.
- UPDATE (1 cycle):
  - If E[0]=1, acc ← mult1 result.
  - base ← mult2 result.
  - E ← E>>1; iteration counter +1.
  - After BITS iterations go to FIN, else go to MUL.
- FIN: r ← acc; done ← 1; go to IDLE.
- Constant-time: all BITS exponent bits are processed regardless of value (no early exit unless the configuration macro below is defined).
- e==0 gives r=one_n. n==1 gives r=0.
- Operands m ≥ n are legal; REDUCE handles them.

## Timing
- Reset values: r=0, done=0, busy=0, state=IDLE.
- START sampled at edge k; busy=1 from k.
- done rises at edge k + BITS + BITS·(BITS+1) + 1, which is 4225 for BITS=64. r is valid at the same edge.
- n==0: done=1 and r=0 at edge k+1.
- done and r hold until the next accepted START. done drops at the edge START is sampled, while r holds its old value until FIN.
- busy falls the same edge done rises.
- RESET mid-operation: at the next edge, state=IDLE, done=0, busy=0, r=0. The operation is abandoned with no residue.
- RESET and START asserted together: RESET wins.

## Configuration
- MODEXP_EARLY_EXIT_EN
  - Undefined (default): fixed latency as above.
  - Defined: before entering each MUL, and after REDUCE, if the remaining E==0 go directly to FIN.
  - Latency with the macro = BITS + L·(BITS+1) + 1, where L = index of the highest set bit of e, plus 1 (L=0 for e=0).
  - Results are identical with and without the macro.

## Test plan
- m=4, e=13, n=497, START pulse -> r=445; done at k+4225 (macro off) or k+325 (macro on, L=4); busy low the same edge.
- m=65, e=17, n=3233 -> r=2790; then m=2790, e=2753, n=3233 -> r=65 (round-trip decrypt).
- m=1000, e=1, n=7 -> r=6. m=2, e=0, n=7 -> r=1. m=5, e=3, n=1 -> r=0.
- n=0, m=9, e=9 -> r=0, done=1 at k+1.
- START pulses repeated while busy -> ignored, result unchanged. RESET at k+100 -> done=0, busy=0, r=0 next edge. A fresh START afterwards gives the correct result.
- After done, hold done=1 for 50 cycles with m/e/n changed -> r stable. A new START drops done at the sampling edge.
